// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dp_pkg
//  Description : Shared encodings for datapath_core: bus source select,
//                ALU operation codes, FSM states and the pending-strobe record
//                captured when a memory micro-op is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
package dp_pkg;

   // Bus source select
   localparam logic [1:0] c_BUS_NONE = 2'b00;
   localparam logic [1:0] c_BUS_PC   = 2'b01;
   localparam logic [1:0] c_BUS_DR   = 2'b10;
   localparam logic [1:0] c_BUS_MEM  = 2'b11;

   // ALU operations (a = AC, b = bus)
   localparam logic [2:0] c_ALU_ADD  = 3'd0;
   localparam logic [2:0] c_ALU_SUB  = 3'd1;
   localparam logic [2:0] c_ALU_AND  = 3'd2;
   localparam logic [2:0] c_ALU_OR   = 3'd3;
   localparam logic [2:0] c_ALU_XOR  = 3'd4;
   localparam logic [2:0] c_ALU_NOT  = 3'd5;
   localparam logic [2:0] c_ALU_PASS = 3'd6;
   localparam logic [2:0] c_ALU_SHL  = 3'd7;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Micro-op strobes plus ALU select, held while a memory read is pending
   typedef struct packed {
      logic       ar_load;
      logic       pc_load;
      logic       pc_inc;
      logic       dr_load;
      logic       ir_load;
      logic       ac_load;
      logic       ac_inc;
      logic [2:0] alu_sel;
   } pend_t;

endpackage
`default_nettype wire

// File: rtl/dp_alu.sv
`default_nettype none
// ============================================================================
//  Module      : dp_alu
//  Description : Combinational ALU for datapath_core. Produces the truncated
//                result, carry/borrow/shifted-out bit and signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module dp_alu
   import dp_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [2:0]        sel_i,
   output logic [DATA_W-1:0] result_o,
   output logic              carry_o,
   output logic              overflow_o
);

   logic [DATA_W:0] w_wide;

   // Operation select; carry is borrow for SUB and the lost MSB for SHL
   always_comb begin
      w_wide     = '0;
      result_o   = '0;
      carry_o    = 1'b0;
      overflow_o = 1'b0;
      case (sel_i)
         c_ALU_ADD: begin
            w_wide     = {1'b0, a_i} + {1'b0, b_i};
            result_o   = w_wide[DATA_W-1:0];
            carry_o    = w_wide[DATA_W];
            overflow_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                         (w_wide[DATA_W-1] != a_i[DATA_W-1]);
         end
         c_ALU_SUB: begin
            w_wide     = {1'b0, a_i} - {1'b0, b_i};
            result_o   = w_wide[DATA_W-1:0];
            carry_o    = w_wide[DATA_W];
            overflow_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                         (w_wide[DATA_W-1] != a_i[DATA_W-1]);
         end
         c_ALU_AND:  result_o = a_i & b_i;
         c_ALU_OR:   result_o = a_i | b_i;
         c_ALU_XOR:  result_o = a_i ^ b_i;
         c_ALU_NOT:  result_o = ~a_i;
         c_ALU_PASS: result_o = b_i;
         c_ALU_SHL: begin
            result_o = {a_i[DATA_W-2:0], 1'b0};
            carry_o  = a_i[DATA_W-1];
         end
         default:    result_o = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/datapath_core.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_core
//  Description : Single-accumulator datapath (AR, PC, DR, IR, AC, ALU) around
//                one encoded internal bus, with a req/ack memory read that
//                supports wait states and an optional timeout abort.
//                Optional feature macro: DP_FLAGS_EN adds a {Z,N,C,V} flags
//                register and the flags_o port.
//  Revision    : 1.0 - initial release
// ============================================================================
module datapath_core
   import dp_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int PC_W    = 6,
   parameter int DR_W    = 8,
   parameter int OPC_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        bus_sel_i,
   input  logic              ar_load_i,
   input  logic              pc_load_i,
   input  logic              pc_inc_i,
   input  logic              dr_load_i,
   input  logic              ir_load_i,
   input  logic              ac_load_i,
   input  logic              ac_inc_i,
   input  logic [2:0]        alu_sel_i,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              mem_req_o,
   output logic [DATA_W-1:0] mem_addr_o,
   output logic              busy_o,
   output logic              mem_err_o,
   output logic [DATA_W-1:0] addr_o,
   output logic [DATA_W-1:0] acc_o,
   output logic [PC_W-1:0]   pc_out_o,
   output logic [DR_W-1:0]   dr_out_o,
   output logic [OPC_W-1:0]  instr_o
`ifdef DP_FLAGS_EN
   ,
   output logic [3:0]        flags_o
`endif
);

   // Wide enough to hold TIMEOUT itself; TIMEOUT = 0 leaves the counter free-running
   localparam int CNT_W = $clog2(TIMEOUT + 2);

   state_t              state_q;
   pend_t               pend_q;
   logic [DATA_W-1:0]   mem_addr_q;
   logic [CNT_W-1:0]    wcnt_q;
   logic                mem_err_q;

   logic [DATA_W-1:0]   ar_q, ar_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DR_W-1:0]     dr_q, dr_d;
   logic [OPC_W-1:0]    ir_q, ir_d;
   logic [DATA_W-1:0]   ac_q, ac_d;

   pend_t               w_cmd;
   pend_t               w_exec;
   logic [DATA_W-1:0]   w_bus;
   logic                w_any_strobe;
   logic                w_accept;
   logic                w_timeout;
   logic [CNT_W-1:0]    w_wcnt_inc;
   logic [DATA_W-1:0]   w_alu_res;
   logic                w_alu_c;
   logic                w_alu_v;

   assign w_cmd        = '{ar_load: ar_load_i, pc_load: pc_load_i, pc_inc: pc_inc_i,
                           dr_load: dr_load_i, ir_load: ir_load_i, ac_load: ac_load_i,
                           ac_inc: ac_inc_i, alu_sel: alu_sel_i};
   assign w_any_strobe = ar_load_i | pc_load_i | pc_inc_i | dr_load_i |
                         ir_load_i | ac_load_i | ac_inc_i;
   assign w_accept     = (state_q == ST_IDLE) && (bus_sel_i == c_BUS_MEM) && w_any_strobe;
   assign w_wcnt_inc   = wcnt_q + 1'b1;
   // Ack has priority: a timeout only fires when the same edge sees no ack
   assign w_timeout    = (state_q == ST_WAIT) && !mem_ack_i && (TIMEOUT != 0) &&
                         (w_wcnt_inc == CNT_W'(TIMEOUT));

   // Pick the bus value and the strobes that execute at this edge
   always_comb begin
      w_bus  = '0;
      w_exec = '0;
      if (state_q == ST_WAIT) begin
         w_bus = mem_rdata_i;
         if (mem_ack_i) w_exec = pend_q;
      end else begin
         case (bus_sel_i)
            c_BUS_PC:  w_bus[PC_W-1:0] = pc_q;
            c_BUS_DR:  w_bus[DR_W-1:0] = dr_q;
            c_BUS_MEM: w_bus = mem_rdata_i;
            default:   w_bus = '0;
         endcase
         if (bus_sel_i != c_BUS_MEM) w_exec = w_cmd;
      end
   end

   dp_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i        (ac_q),
      .b_i        (w_bus),
      .sel_i      (w_exec.alu_sel),
      .result_o   (w_alu_res),
      .carry_o    (w_alu_c),
      .overflow_o (w_alu_v)
   );

   // Next-state of the architectural registers; load beats increment
   always_comb begin
      ar_d = ar_q;
      pc_d = pc_q;
      dr_d = dr_q;
      ir_d = ir_q;
      ac_d = ac_q;
      if (w_exec.ar_load) ar_d = w_bus;
      if (w_exec.pc_load)     pc_d = w_bus[PC_W-1:0];
      else if (w_exec.pc_inc) pc_d = pc_q + 1'b1;
      if (w_exec.dr_load) dr_d = w_bus[DR_W-1:0];
      if (w_exec.ir_load) ir_d = w_bus[DR_W-1 -: OPC_W];
      if (w_exec.ac_load)     ac_d = w_alu_res;
      else if (w_exec.ac_inc) ac_d = ac_q + 1'b1;
   end

   // Architectural register file
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar_q <= '0;
         pc_q <= '0;
         dr_q <= '0;
         ir_q <= '0;
         ac_q <= '0;
      end else begin
         ar_q <= ar_d;
         pc_q <= pc_d;
         dr_q <= dr_d;
         ir_q <= ir_d;
         ac_q <= ac_d;
      end
   end

   // Memory-read FSM: latch command and address, wait for ack or timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         pend_q     <= '0;
         mem_addr_q <= '0;
         wcnt_q     <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         mem_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_accept) begin
                  pend_q     <= w_cmd;
                  mem_addr_q <= ar_q;
                  wcnt_q     <= '0;
                  state_q    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               wcnt_q <= w_wcnt_inc;
               if (mem_ack_i) begin
                  pend_q  <= '0;
                  state_q <= ST_IDLE;
               end else if (w_timeout) begin
                  pend_q    <= '0;
                  mem_err_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef DP_FLAGS_EN
   logic [3:0] flags_q;

   // Flags follow ac_load only; ac_inc leaves them alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= '0;
      end else if (w_exec.ac_load) begin
         flags_q <= {(w_alu_res == '0), w_alu_res[DATA_W-1], w_alu_c, w_alu_v};
      end
   end

   assign flags_o = flags_q;
`else
   logic w_unused_flags;
   assign w_unused_flags = w_alu_c ^ w_alu_v;
`endif

   assign mem_req_o  = (state_q == ST_WAIT);
   assign busy_o     = (state_q == ST_WAIT);
   assign mem_err_o  = mem_err_q;
   assign mem_addr_o = mem_addr_q;
   assign addr_o     = ar_q;
   assign acc_o      = ac_q;
   assign pc_out_o   = pc_q;
   assign dr_out_o   = dr_q;
   assign instr_o    = ir_q;

endmodule
`default_nettype wire
